frv_leak_fence_ctrl: RTL and testbench

Sequencer for the leakage-fence instruction. On a fence it snapshots the ALCFG configuration register, walks the enabled resources lowest-index first, and issues one scrub request per resource carrying the current PRNG word. It steps the PRNG once per completed scrub and stalls the pipeline until the walk finishes. It sits between the execute stage, the ALCFG CSR write path, the PRNG LFSR and the scrub-capable resources (register file, operand latches, etc.).

---
 rtl/frv_leak_fence_ctrl_if.sv | 31 +++
 rtl/frv_leak_fence_ctrl.sv | 151 +++++++++++++++
 tb/tb_frv_leak_fence_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frv_leak_fence_ctrl_if.sv
// Bundle of the leakage-fence controller's pipeline, CSR, PRNG and scrub signals.
// master: the fence controller. slave: the pipeline, CSR path, PRNG and resources.
interface frv_leak_fence_ctrl_if #(
  parameter int XLEN = 32,
  parameter int NRES = 13,
  parameter int IDXW = 4
);
  logic            fence_req;
  logic            fence_ack;
  logic            stall;
  logic            alcfg_wen;
  logic [NRES-1:0] alcfg_wdata;
  logic [NRES-1:0] alcfg;
  logic [XLEN-1:0] prng;
  logic            prng_step;
  logic            scrub_valid;
  logic [IDXW-1:0] scrub_idx;
  logic [XLEN-1:0] scrub_data;
  logic            scrub_ready;
  logic            scrub_err;

  modport master (
    input  fence_req, alcfg_wen, alcfg_wdata, prng, scrub_ready,
    output fence_ack, stall, alcfg, prng_step, scrub_valid, scrub_idx, scrub_data, scrub_err
  );

  modport slave (
    output fence_req, alcfg_wen, alcfg_wdata, prng, scrub_ready,
    input  fence_ack, stall, alcfg, prng_step, scrub_valid, scrub_idx, scrub_data, scrub_err
  );
endinterface

// File: rtl/frv_leak_fence_ctrl.sv
// Leakage-fence sequencer: snapshots ALCFG when a fence is accepted, scrubs each
// enabled resource lowest index first with the current PRNG word, steps the PRNG
// after every completed scrub, and stalls the pipeline until the walk is done.
// Optional macro FRV_LEAK_FENCE_TIMEOUT_EN: abandons a resource that does not
// accept its scrub within TIMEOUT_CYCLES and raises the sticky scrub_err flag.
module frv_leak_fence_ctrl #(
  parameter int              XLEN              = 32,
  parameter int              NRES              = 13,
  parameter logic [NRES-1:0] ALCFG_RESET_VALUE = 13'b0,
  parameter int              IDXW              = 4,
  parameter int              TIMEOUT_CYCLES    = 16
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  frv_leak_fence_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_SCRUB = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [IDXW-1:0] lowest_set(input logic [NRES-1:0] v);
    logic [IDXW-1:0] idx;
    idx = {IDXW{1'b0}};
    for (int i = NRES - 1; i >= 0; i--) begin
      idx = v[i] ? IDXW'(i) : idx;
    end
    return idx;
  endfunction

  logic [1:0]      state_r;
  logic [NRES-1:0] pending_r;
  logic [NRES-1:0] alcfg_r;
  logic            fence_ack_r;
  logic            stall_r;
  logic            prng_step_r;
  logic            scrub_valid_r;
  logic [IDXW-1:0] scrub_idx_r;
  logic [XLEN-1:0] scrub_data_r;
  logic [NRES-1:0] clr_mask_s;

  // One-hot mask of the resource currently being scrubbed.
  assign clr_mask_s = {{(NRES-1){1'b0}}, 1'b1} << scrub_idx_r;

`ifdef FRV_LEAK_FENCE_TIMEOUT_EN
  localparam int              CNTW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNTW-1:0] TMO_LAST = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  logic [CNTW-1:0] tmo_cnt_r;
  logic            scrub_err_r;
  assign bus.scrub_err = scrub_err_r;
`else
  assign bus.scrub_err = 1'b0;
`endif

  // Fence FSM, ALCFG register and all registered outputs.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_r       <= ST_IDLE;
      pending_r     <= {NRES{1'b0}};
      alcfg_r       <= ALCFG_RESET_VALUE;
      fence_ack_r   <= 1'b0;
      stall_r       <= 1'b0;
      prng_step_r   <= 1'b0;
      scrub_valid_r <= 1'b0;
      scrub_idx_r   <= {IDXW{1'b0}};
      scrub_data_r  <= {XLEN{1'b0}};
`ifdef FRV_LEAK_FENCE_TIMEOUT_EN
      tmo_cnt_r     <= {CNTW{1'b0}};
      scrub_err_r   <= 1'b0;
`endif
    end else begin
      fence_ack_r <= 1'b0;
      prng_step_r <= 1'b0;
      // CSR writes land at any time; the in-flight fence works from pending_r.
      if (bus.alcfg_wen) begin
        alcfg_r <= bus.alcfg_wdata;
      end else begin
        alcfg_r <= alcfg_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (bus.fence_req) begin
            pending_r <= alcfg_r;
            stall_r   <= 1'b1;
            state_r   <= ST_SCAN;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (pending_r == {NRES{1'b0}}) begin
            fence_ack_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            scrub_idx_r   <= lowest_set(pending_r);
            scrub_data_r  <= bus.prng;
            scrub_valid_r <= 1'b1;
            state_r       <= ST_SCRUB;
`ifdef FRV_LEAK_FENCE_TIMEOUT_EN
            tmo_cnt_r     <= {CNTW{1'b0}};
`endif
          end
        end
        ST_SCRUB: begin
          if (scrub_valid_r && bus.scrub_ready) begin
            pending_r     <= pending_r & ~clr_mask_s;
            scrub_valid_r <= 1'b0;
            prng_step_r   <= 1'b1;
            state_r       <= ST_SCAN;
          end
`ifdef FRV_LEAK_FENCE_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LAST) begin
            // Resource never answered: drop it without consuming a PRNG word.
            pending_r     <= pending_r & ~clr_mask_s;
            scrub_valid_r <= 1'b0;
            scrub_err_r   <= 1'b1;
            state_r       <= ST_SCAN;
          end else begin
            tmo_cnt_r     <= tmo_cnt_r + CNT_ONE;
          end
`else
          else begin
            state_r       <= ST_SCRUB;
          end
`endif
        end
        ST_DONE: begin
          stall_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          stall_r       <= 1'b0;
          scrub_valid_r <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.fence_ack   = fence_ack_r;
  assign bus.stall       = stall_r;
  assign bus.alcfg       = alcfg_r;
  assign bus.prng_step   = prng_step_r;
  assign bus.scrub_valid = scrub_valid_r;
  assign bus.scrub_idx   = scrub_idx_r;
  assign bus.scrub_data  = scrub_data_r;

endmodule

// File: tb/tb_frv_leak_fence_ctrl.sv
// Self-checking bench for frv_leak_fence_ctrl: directed vector table, hand-written
// corner sequences, and randomized fences checked against a transaction-level model.
module tb_frv_leak_fence_ctrl;
  localparam int XLEN = 32;
  localparam int NRES = 13;
  localparam int IDXW = 4;
  localparam int TMO  = 16;

  typedef struct {
    logic [NRES-1:0] cfg;
    int              wait_c;
    int              n;
    int              lat;
  } vec_t;

  logic g_clk;
  logic g_reset;
  int   errors;
  int   checks;

  logic [NRES-1:0] alcfg_m;
  logic [XLEN-1:0] prng_prev;

  frv_leak_fence_ctrl_if #(.XLEN(XLEN), .NRES(NRES), .IDXW(IDXW)) bus();

  frv_leak_fence_ctrl #(
    .XLEN(XLEN), .NRES(NRES), .ALCFG_RESET_VALUE(13'b0), .IDXW(IDXW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .g_clk(g_clk),
    .g_reset(g_reset),
    .bus(bus)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; update the ALCFG model from what was driven; sample at +1.
  task automatic tick();
    logic w;
    logic [NRES-1:0] wd;
    logic r;
    w  = bus.alcfg_wen;
    wd = bus.alcfg_wdata;
    r  = g_reset;
    @(posedge g_clk);
    if (r) alcfg_m = '0;
    else if (w) alcfg_m = wd;
    #1;
    prng_prev     = bus.prng;
    bus.prng      = $urandom();
    bus.alcfg_wen = 1'b0;
  endtask

  task automatic write_cfg(input logic [NRES-1:0] v);
    bus.alcfg_wen   = 1'b1;
    bus.alcfg_wdata = v;
    tick();
    chk("alcfg_write", bus.alcfg, v);
  endtask

  // Run one fence. wait_cfg<0 picks a random ready delay per scrub.
  task automatic do_fence(input int wait_cfg, input logic wen, input logic [NRES-1:0] wd,
                          input bit rnd_writes, output int lat, output int lat_exp,
                          output int nscr, output int nsteps);
    logic [NRES-1:0] rem;
    logic [IDXW-1:0] cap_idx;
    logic [XLEN-1:0] cap_data;
    int c, wv, exp_idx;
    bit hs_prev, acked, active;
    rem = alcfg_m;
    bus.fence_req   = 1'b1;
    bus.alcfg_wen   = wen;
    bus.alcfg_wdata = wd;
    lat = 0; lat_exp = 2; nscr = 0; nsteps = 0;
    hs_prev = 1'b0; acked = 1'b0; active = 1'b0; c = 0; wv = 0;
    cap_idx = '0; cap_data = '0;
    while (!acked && lat < 400) begin
      tick();
      lat++;
      chk("prng_step", bus.prng_step, hs_prev);
      nsteps += int'(bus.prng_step);
      chk("alcfg", bus.alcfg, alcfg_m);
      chk("stall", bus.stall, 1'b1);
      if (bus.scrub_valid && !active) begin
        active = 1'b1;
        c = 0;
        chk("scrub_expected", (rem != '0), 1'b1);
        exp_idx = 0;
        for (int i = NRES - 1; i >= 0; i--) if (rem[i]) exp_idx = i;
        chk("scrub_idx", bus.scrub_idx, exp_idx);
        chk("scrub_data", bus.scrub_data, prng_prev);
        cap_idx  = bus.scrub_idx;
        cap_data = bus.scrub_data;
        rem[exp_idx] = 1'b0;
        wv = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        lat_exp += 2 + wv;
        nscr++;
      end else if (bus.scrub_valid) begin
        chk("idx_stable", bus.scrub_idx, cap_idx);
        chk("data_stable", bus.scrub_data, cap_data);
      end
      if (bus.fence_ack) begin
        acked = 1'b1;
        chk("ack_remaining", rem, '0);
      end
      hs_prev = 1'b0;
      if (bus.scrub_valid) begin
        bus.scrub_ready = (c >= wv);
        hs_prev = bus.scrub_ready;
        c++;
        if (bus.scrub_ready) active = 1'b0;
      end else begin
        bus.scrub_ready = 1'b0;
      end
      if (acked) bus.fence_req = 1'b0;
      if (rnd_writes && $urandom_range(0, 3) == 0) begin
        bus.alcfg_wen   = 1'b1;
        bus.alcfg_wdata = NRES'($urandom());
      end
    end
    chk("ack_seen", acked, 1'b1);
    bus.fence_req = 1'b0;
    tick();
    chk("post_ack_pulse", bus.fence_ack, 1'b0);
    chk("post_stall", bus.stall, 1'b0);
    chk("post_step", bus.prng_step, hs_prev);
    bus.scrub_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int lat, lat_exp, nscr, nsteps, cnt;
    bit bad;
    logic [NRES-1:0] snap;
    errors = 0; checks = 0;
    alcfg_m = '0; prng_prev = '0;
    vecs[0] = '{cfg: 13'h0000, wait_c: 0, n: 0,  lat: 2};
    vecs[1] = '{cfg: 13'h1005, wait_c: 0, n: 3,  lat: 8};
    vecs[2] = '{cfg: 13'h0002, wait_c: 5, n: 1,  lat: 9};
    vecs[3] = '{cfg: 13'h1FFF, wait_c: 0, n: 13, lat: 28};
    vecs[4] = '{cfg: 13'h1000, wait_c: 2, n: 1,  lat: 6};
    vecs[5] = '{cfg: 13'h0AAA, wait_c: 1, n: 6,  lat: 20};

    g_reset = 1'b1;
    bus.fence_req = 1'b0; bus.alcfg_wen = 1'b0; bus.alcfg_wdata = '0;
    bus.prng = '0; bus.scrub_ready = 1'b0;
    tick(); tick();
    chk("rst_alcfg", bus.alcfg, 13'b0);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_ack", bus.fence_ack, 1'b0);
    chk("rst_step", bus.prng_step, 1'b0);
    chk("rst_valid", bus.scrub_valid, 1'b0);
    chk("rst_idx", bus.scrub_idx, 4'd0);
    chk("rst_data", bus.scrub_data, 32'd0);
    chk("rst_err", bus.scrub_err, 1'b0);
    g_reset = 1'b0;
    tick();

    // Directed vector table.
    foreach (vecs[k]) begin
      write_cfg(vecs[k].cfg);
      do_fence(vecs[k].wait_c, 1'b0, '0, 1'b0, lat, lat_exp, nscr, nsteps);
      chk($sformatf("vec%0d_lat", k), lat, vecs[k].lat);
      chk($sformatf("vec%0d_nscr", k), nscr, vecs[k].n);
      chk($sformatf("vec%0d_steps", k), nsteps, vecs[k].n);
    end

    // Write in the acceptance cycle affects only the next fence.
    write_cfg(13'h0000);
    do_fence(0, 1'b1, 13'h1FFF, 1'b0, lat, lat_exp, nscr, nsteps);
    chk("samecyc_nscr", nscr, 0);
    chk("samecyc_lat", lat, 2);
    chk("samecyc_alcfg", bus.alcfg, 13'h1FFF);
    do_fence(0, 1'b0, '0, 1'b0, lat, lat_exp, nscr, nsteps);
    chk("next_nscr", nscr, 13);
    chk("next_lat", lat, 28);

    // Reset in the middle of a scrub.
    write_cfg(13'h0002);
    bus.fence_req = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (!bus.scrub_valid && cnt < 20);
    chk("mid_valid_seen", bus.scrub_valid, 1'b1);
    g_reset = 1'b1;
    bus.fence_req = 1'b0;
    tick();
    chk("mid_rst_stall", bus.stall, 1'b0);
    chk("mid_rst_valid", bus.scrub_valid, 1'b0);
    chk("mid_rst_alcfg", bus.alcfg, 13'b0);
    chk("mid_rst_ack", bus.fence_ack, 1'b0);
    chk("mid_rst_step", bus.prng_step, 1'b0);
    chk("mid_rst_idx", bus.scrub_idx, 4'd0);
    chk("mid_rst_data", bus.scrub_data, 32'd0);
    g_reset = 1'b0;
    bus.scrub_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.fence_ack || bus.stall || bus.prng_step || bus.scrub_valid) bad = 1'b1;
    end
    chk("mid_rst_quiet", bad, 1'b0);
    bus.scrub_ready = 1'b0;

`ifdef FRV_LEAK_FENCE_TIMEOUT_EN
    // Resource 0 never answers: abandoned after TMO cycles, resource 1 still scrubbed.
    write_cfg(13'h0003);
    bus.fence_req = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (!bus.scrub_valid && cnt < 20);
    chk("tmo_idx0", bus.scrub_idx, 4'd0);
    cnt = 1;
    bus.scrub_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.scrub_valid && bus.scrub_idx == 4'd0) cnt++;
      else break;
    end
    chk("tmo_cycles", cnt, TMO);
    chk("tmo_no_step", bus.prng_step, 1'b0);
    chk("tmo_err", bus.scrub_err, 1'b1);
    tick();
    chk("tmo_idx1", bus.scrub_idx, 4'd1);
    chk("tmo_valid1", bus.scrub_valid, 1'b1);
    bus.scrub_ready = 1'b1;
    tick();
    bus.scrub_ready = 1'b0;
    chk("tmo_step1", bus.prng_step, 1'b1);
    cnt = 0;
    while (!bus.fence_ack && cnt < 20) begin tick(); cnt++; end
    chk("tmo_acked", bus.fence_ack, 1'b1);
    bus.fence_req = 1'b0;
    tick();
    chk("tmo_err_sticky", bus.scrub_err, 1'b1);
`else
    chk("err_tied_low", bus.scrub_err, 1'b0);
`endif

    // Randomized fences with concurrent CSR writes and random ready delays.
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 1) == 1) write_cfg(NRES'($urandom() & $urandom()));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        chk("idle_stall", bus.stall, 1'b0);
      end
      snap = alcfg_m;
      do_fence(-1, 1'($urandom_range(0, 1)), NRES'($urandom()), 1'b1, lat, lat_exp, nscr, nsteps);
      chk("rnd_lat", lat, lat_exp);
      chk("rnd_nscr", nscr, $countones(snap));
      chk("rnd_steps", nsteps, nscr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
